// File: rtl/clock_sched_ctrl.sv
// Sequencer for a register-based clock generator: programmable high/low phase lengths, gate changes on falling boundaries.
// Optional CYCLE_CNT output (rising-edge counter) is enabled by defining CLK_SCHED_CYCLE_COUNT_EN.
module clock_sched_ctrl #(
    parameter int   CNT_W     = 8,
    parameter int   INIT_HI   = 1,
    parameter int   INIT_LO   = 1,
    parameter logic INIT_GATE = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [CNT_W-1:0] CFG_HI,
    input  logic [CNT_W-1:0] CFG_LO,
    input  logic             CFG_VALID,
    output logic             CFG_READY,
    input  logic             RUN,
    input  logic             GATE_REQ,
    output logic             GATE_ACK,
    output logic             CLK_VAL,
    output logic             CLK_VAL_EN,
    output logic             COND,
    output logic             COND_EN,
    output logic             RISE,
    output logic             BUSY
`ifdef CLK_SCHED_CYCLE_COUNT_EN
    ,
    output logic [15:0]      CYCLE_CNT
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_HI  = (INIT_HI == 0) ? ONE : CNT_W'(INIT_HI);
    localparam logic [CNT_W-1:0] RST_LO  = (INIT_LO == 0) ? ONE : CNT_W'(INIT_LO);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_hi;
    logic [CNT_W-1:0] act_lo;
    logic [CNT_W-1:0] pend_hi;
    logic [CNT_W-1:0] pend_lo;
    logic             pend_valid;

    logic             cnt_zero;
    logic             go_high;
    logic             go_low;
    logic             go_idle;
    logic             capture;
    logic             activate;
    logic             gate_upd;
    logic [CNT_W-1:0] next_hi;

    assign cnt_zero = (cnt == '0);
    assign capture  = CFG_VALID && CFG_READY;
    assign GATE_ACK = (COND == GATE_REQ);

    always_comb begin
        go_high    = 1'b0;
        go_low     = 1'b0;
        go_idle    = 1'b0;
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (RUN) begin
                    go_high    = 1'b1;
                    next_state = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (cnt_zero) begin
                    go_low     = 1'b1;
                    next_state = ST_LOW;
                end
            end
            ST_LOW: begin
                if (cnt_zero && RUN) begin
                    go_high    = 1'b1;
                    next_state = ST_HIGH;
                end else if (cnt_zero) begin
                    go_idle    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Pending config takes effect only at a rising boundary, or straight away when parked idle.
    always_comb begin
        activate = pend_valid && (go_high || (state == ST_IDLE && !RUN));
        next_hi  = activate ? pend_hi : act_hi;
        gate_upd = (state == ST_IDLE || go_low) && (GATE_REQ != COND);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (go_high) begin
                cnt <= next_hi - ONE;
            end else if (go_low) begin
                cnt <= act_lo - ONE;
            end else if (state != ST_IDLE && !cnt_zero) begin
                cnt <= cnt - ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            CLK_VAL    <= 1'b0;
            CLK_VAL_EN <= 1'b0;
            RISE       <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            if (go_high) begin
                CLK_VAL <= 1'b1;
            end else if (go_low || go_idle) begin
                CLK_VAL <= 1'b0;
            end
            CLK_VAL_EN <= go_high || go_low;
            RISE       <= go_high;
            BUSY       <= (next_state != ST_IDLE);
        end
    end

    // The ready flag drops with the capture but only reopens one cycle after activation.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pend_valid <= 1'b0;
            pend_hi    <= RST_HI;
            pend_lo    <= RST_LO;
            act_hi     <= RST_HI;
            act_lo     <= RST_LO;
            CFG_READY  <= 1'b1;
        end else begin
            if (activate) begin
                act_hi     <= pend_hi;
                act_lo     <= pend_lo;
                pend_valid <= 1'b0;
            end
            if (capture) begin
                pend_valid <= 1'b1;
                pend_hi    <= (CFG_HI == '0) ? ONE : CFG_HI;
                pend_lo    <= (CFG_LO == '0) ? ONE : CFG_LO;
            end
            CFG_READY <= capture ? 1'b0 : !pend_valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            COND    <= INIT_GATE;
            COND_EN <= 1'b0;
        end else begin
            if (gate_upd) begin
                COND <= GATE_REQ;
            end
            COND_EN <= gate_upd;
        end
    end

`ifdef CLK_SCHED_CYCLE_COUNT_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            CYCLE_CNT <= 16'd0;
        end else if (go_high) begin
            CYCLE_CNT <= CYCLE_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clock_sched_ctrl.sv
// Bench for clock_sched_ctrl: period-position model checked every cycle, plus directed literal checks.
module tb_clock_sched_ctrl;

    logic       CLK;
    logic       RST_N;
    logic [7:0] CFG_HI;
    logic [7:0] CFG_LO;
    logic       CFG_VALID;
    logic       CFG_READY;
    logic       RUN;
    logic       GATE_REQ;
    logic       GATE_ACK;
    logic       CLK_VAL;
    logic       CLK_VAL_EN;
    logic       COND;
    logic       COND_EN;
    logic       RISE;
    logic       BUSY;
`ifdef CLK_SCHED_CYCLE_COUNT_EN
    logic [15:0] CYCLE_CNT;
`endif

    clock_sched_ctrl #(
        .CNT_W(8), .INIT_HI(1), .INIT_LO(1), .INIT_GATE(1'b1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .CFG_HI(CFG_HI), .CFG_LO(CFG_LO), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
        .RUN(RUN), .GATE_REQ(GATE_REQ), .GATE_ACK(GATE_ACK),
        .CLK_VAL(CLK_VAL), .CLK_VAL_EN(CLK_VAL_EN),
        .COND(COND), .COND_EN(COND_EN), .RISE(RISE), .BUSY(BUSY)
`ifdef CLK_SCHED_CYCLE_COUNT_EN
        , .CYCLE_CNT(CYCLE_CNT)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: tracks position inside the current period rather than a phase down-counter.
    bit m_valid = 0;
    bit m_on, m_pend, m_ready;
    int m_pos, m_hi, m_lo, m_phi, m_plo;
    bit e_clk, e_en, e_rise, e_cond, e_cond_en, e_busy;
    bit cap, start, fall, stop, gate_ok, old_pend;

    always @(posedge CLK) begin
        if (!RST_N) begin
            m_valid = 1; m_on = 0; m_pos = 0; m_hi = 1; m_lo = 1;
            m_pend = 0; m_phi = 1; m_plo = 1; m_ready = 1;
            e_clk = 0; e_en = 0; e_rise = 0; e_cond = 1; e_cond_en = 0; e_busy = 0;
        end else if (m_valid) begin
            cap = CFG_VALID && m_ready;
            old_pend = m_pend;
            start = 0; fall = 0; stop = 0;
            if (!m_on) begin
                start = RUN;
            end else if (m_pos == m_hi + m_lo - 1) begin
                start = RUN;
                stop  = !RUN;
            end else if (m_pos + 1 == m_hi) begin
                fall = 1;
            end
            gate_ok = (!m_on || fall) && (GATE_REQ != e_cond);
            if (old_pend && (start || (!m_on && !RUN))) begin
                m_hi = m_phi; m_lo = m_plo; m_pend = 0;
            end
            if (cap) begin
                m_pend = 1;
                m_phi = (CFG_HI == 0) ? 1 : int'(CFG_HI);
                m_plo = (CFG_LO == 0) ? 1 : int'(CFG_LO);
            end
            m_ready = cap ? 1'b0 : !old_pend;
            if (start) begin
                m_on = 1; m_pos = 0;
            end else if (stop) begin
                m_on = 0;
            end else if (m_on) begin
                m_pos = m_pos + 1;
            end
            e_clk = m_on && (m_pos < m_hi);
            e_en = start || fall;
            e_rise = start;
            e_busy = m_on;
            if (gate_ok) e_cond = GATE_REQ;
            e_cond_en = gate_ok;
        end
    end

    logic [7:0] act_vec, exp_vec;
    always @(negedge CLK) begin
        if (m_valid) begin
            act_vec = {CLK_VAL, CLK_VAL_EN, RISE, COND, COND_EN, BUSY, CFG_READY, GATE_ACK};
            exp_vec = {e_clk, e_en, e_rise, e_cond, e_cond_en, e_busy, m_ready, (e_cond == GATE_REQ)};
            n_checks++;
            if (act_vec === exp_vec) n_pass++;
            else $display("[TB] FAIL cycle_outputs t=%0t {clk,en,rise,cond,cond_en,busy,ready,ack} got %b want %b",
                          $time, act_vec, exp_vec);
        end
    end

    task automatic check_output(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %b want %b", name, actual, expected);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic apply_stimulus(input logic run, input logic gate, input logic valid,
                                  input logic [7:0] hi, input logic [7:0] lo);
        RUN = run; GATE_REQ = gate; CFG_VALID = valid; CFG_HI = hi; CFG_LO = lo;
    endtask

    task automatic wait_for_rise(input int budget);
        int k;
        k = 0;
        while (RISE !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        check_output("wait_for_rise", RISE, 1'b1);
    endtask

    initial begin
        $display("[TB] start");
        RST_N = 1'b0;
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        tick(2);
        RST_N = 1'b1;

        // Idle after reset with RUN low.
        tick(20);
        check_output("idle_clk_val", CLK_VAL, 1'b0);
        check_output("idle_cond", COND, 1'b1);
        check_output("idle_ready", CFG_READY, 1'b1);
        check_output("idle_busy", BUSY, 1'b0);

        // Default hi=lo=1: strobe every cycle.
        RUN = 1'b1;
        tick(1);
        check_output("first_rise", RISE, 1'b1);
        check_output("first_clk_val", CLK_VAL, 1'b1);
        tick(1);
        check_output("first_fall_val", CLK_VAL, 1'b0);
        check_output("first_fall_en", CLK_VAL_EN, 1'b1);
        tick(1);
        check_output("second_rise", RISE, 1'b1);

        // hi=2 lo=3 offered while running.
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'd2, 8'd3);
        tick(1);
        CFG_VALID = 1'b0;
        check_output("cfg_ready_low", CFG_READY, 1'b0);
        tick(1);
        check_output("cfg_rise", RISE, 1'b1);
        check_output("cfg_ready_at_rise", CFG_READY, 1'b0);
        tick(1);
        check_output("cfg_ready_back", CFG_READY, 1'b1);
        check_output("hi2_second_high", CLK_VAL, 1'b1);
        tick(1);
        check_output("hi2_fall", CLK_VAL, 1'b0);
        tick(3);
        check_output("period5_rise", RISE, 1'b1);

        // Gate request during HIGH lands on the falling strobe.
        GATE_REQ = 1'b0;
        #1;
        check_output("gate_ack_pending", GATE_ACK, 1'b0);
        tick(1);
        check_output("gate_wait_cond", COND, 1'b1);
        check_output("gate_wait_en", COND_EN, 1'b0);
        tick(1);
        check_output("gate_cond", COND, 1'b0);
        check_output("gate_cond_en", COND_EN, 1'b1);
        check_output("gate_clk_en", CLK_VAL_EN, 1'b1);
        tick(1);
        check_output("gate_en_once", COND_EN, 1'b0);
        check_output("gate_ack", GATE_ACK, 1'b1);
        tick(2);
        check_output("rise_before_stop", RISE, 1'b1);

        // RUN drops mid-HIGH; gate request toggles back before the fall.
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        tick(1);
        GATE_REQ = 1'b0;
        check_output("stop_still_high", CLK_VAL, 1'b1);
        tick(1);
        check_output("stop_fall", CLK_VAL, 1'b0);
        check_output("toggle_back_no_en", COND_EN, 1'b0);
        tick(2);
        check_output("stop_low_busy", BUSY, 1'b1);
        tick(1);
        check_output("stop_idle_busy", BUSY, 1'b0);
        check_output("stop_no_strobe", CLK_VAL_EN, 1'b0);
        tick(5);

        // Zero fields clamp to 1, then reset mid-HIGH.
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        tick(1);
        CFG_VALID = 1'b0;
        check_output("clamp_ready_low", CFG_READY, 1'b0);
        tick(2);
        check_output("clamp_ready_back", CFG_READY, 1'b1);
        RUN = 1'b1;
        tick(1);
        wait_for_rise(4);
        tick(1);
        check_output("clamp_fall", CLK_VAL, 1'b0);
        check_output("clamp_fall_en", CLK_VAL_EN, 1'b1);
        tick(1);
        check_output("clamp_rise", RISE, 1'b1);
        RST_N = 1'b0;
        tick(1);
        check_output("rst_clk_val", CLK_VAL, 1'b0);
        check_output("rst_no_strobe", CLK_VAL_EN, 1'b0);
        check_output("rst_cond", COND, 1'b1);
        check_output("rst_busy", BUSY, 1'b0);
        RST_N = 1'b1;
        RUN = 1'b0;
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_sched_ctrl.md
Name: clock_sched_ctrl

Overview:
Programmable sequencer that drives a register-based clock generator (the CLK_IN/CLK_IN_EN and COND_IN/COND_IN_EN inputs of the clock-making primitive).
- Produces a derived clock with run-time programmable high and low phase lengths, counted in CLK cycles.
- Schedules gate changes so they land only on falling-phase boundaries.
- Accepts new period configuration through a valid/ready handshake, applied glitch-free at the next rising boundary.

Parameters:
CNT_W, 8, width of the phase-length fields and internal down-counter
INIT_HI, 1, high-phase length (cycles) after reset
INIT_LO, 1, low-phase length (cycles) after reset
INIT_GATE, 1, gate value driven on COND after reset

Ports:
CLK  in  1  single clock for all logic
RST_N  in  1  reset, synchronous, active-low
CFG_HI  in  CNT_W  requested high-phase length; 0 is treated as 1
CFG_LO  in  CNT_W  requested low-phase length; 0 is treated as 1
CFG_VALID  in  1  config offer
CFG_READY  out  1  pending-config slot empty
RUN  in  1  1 = generate clock; 0 = finish the current period, then park low
GATE_REQ  in  1  requested gate level
GATE_ACK  out  1  1 when COND equals GATE_REQ
CLK_VAL  out  1  clock value, connects to the generator's CLK_IN
CLK_VAL_EN  out  1  one-cycle update strobe, connects to CLK_IN_EN
COND  out  1  gate value, connects to COND_IN
COND_EN  out  1  one-cycle gate update strobe, connects to COND_IN_EN
RISE  out  1  one-cycle pulse coincident with CLK_VAL_EN when CLK_VAL=1
BUSY  out  1  state is not IDLE

Behaviour:
Reset (RST_N=0 at a CLK edge):
- state=IDLE, CLK_VAL=0, CLK_VAL_EN=0, COND=INIT_GATE, COND_EN=0, RISE=0, BUSY=0, CFG_READY=1.
- Active hi/lo = INIT_HI/INIT_LO; pending slot empty.
- Reset mid-operation: outputs take reset values at that edge with no strobe. The downstream generator is reset in the same domain.

Registers and counting:
- All outputs are registered. GATE_ACK is combinational from COND and GATE_REQ.
- The counter loads (len-1) on entry to a phase and decrements each cycle. The phase ends when count==0.

States:
- IDLE: if RUN=1, go to HIGH, drive CLK_VAL=1, CLK_VAL_EN=1, RISE=1, load hi-1.
- HIGH: if count==0, go to LOW, drive CLK_VAL=0, CLK_VAL_EN=1, load lo-1. Otherwise decrement.
- LOW: if count==0 and RUN=1, go to HIGH (same outputs as IDLE->HIGH). If count==0 and RUN=0, go to IDLE with no strobe. Otherwise decrement.
- CLK_VAL_EN is high for exactly one cycle per transition and never otherwise.
- Derived period = hi+lo CLK cycles. hi=lo=1 gives CLK_VAL_EN high every cycle.

Config handshake:
- Transfer when CFG_VALID && CFG_READY. The values are captured in the pending slot and CFG_READY=0 from the next cycle.
- Pending values become active at the next LOW->HIGH or IDLE->HIGH transition; the loaded count uses the new hi.
- In IDLE with RUN=0, pending becomes active the cycle after capture.
- CFG_READY returns to 1 the cycle after activation.
- A zero field is clamped to 1 at capture.

Gate scheduling:
- A gate update is allowed in IDLE, or in the HIGH->LOW transition cycle, and only when GATE_REQ != COND.
- In that cycle COND<=GATE_REQ and COND_EN=1 for one cycle.
- A request made during HIGH or LOW waits for the next HIGH->LOW transition.
- GATE_REQ toggling back before the update point means no update occurs.

Simultaneous events:
- RUN falling during HIGH: the period still completes (HIGH then LOW), then IDLE.
- A config capture and an activation boundary in the same cycle: the new config is captured, and activates at the following boundary.

Optional Feature:
CLK_SCHED_CYCLE_COUNT_EN
- Defined: adds output CYCLE_CNT [15:0], which increments on every RISE pulse, wraps 0xFFFF->0x0000, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, RUN=0 for 20 cycles -> CLK_VAL=0, CLK_VAL_EN=0, COND=1, CFG_READY=1, BUSY=0 throughout.
2. Defaults, RUN=1 -> first CLK_VAL_EN with CLK_VAL=1 and RISE=1 one cycle later; thereafter CLK_VAL alternates 1,0 every cycle with CLK_VAL_EN=1 each cycle.
3. Running, CFG_HI=2 CFG_LO=3 accepted -> CFG_READY=0 until the next rise; then CLK_VAL=1 for 2 cycles and 0 for 3 cycles, RISE every 5 cycles, CFG_READY=1 one cycle after that rise.
4. hi=2 lo=3, GATE_REQ 1->0 in the first HIGH cycle -> COND changes to 0 with a single COND_EN pulse exactly in the HIGH->LOW strobe cycle; GATE_ACK=0 until then.
5. hi=2 lo=3, RUN 1->0 during HIGH -> CLK_VAL stays 1 for the remaining high cycle(s), then 0 for 3 cycles, then IDLE with BUSY=0 and no further CLK_VAL_EN.
6. CFG_HI=0 CFG_LO=0 captured -> behaves as hi=1 lo=1; RST_N=0 asserted mid-HIGH -> CLK_VAL=0 at the next edge with CLK_VAL_EN=0.
